// File: rtl/imm_gen_pipe_pkg.sv
// imm_gen_pipe_pkg: immediate-format op encodings shared by the generator and its pipeline
`ifndef IMM_GEN_OP_WIDTH
`define IMM_GEN_OP_WIDTH 3
`endif
package imm_gen_pipe_pkg;
  localparam int OP_W = `IMM_GEN_OP_WIDTH;
  typedef logic [OP_W-1:0] op_t;
  localparam op_t IMM_GEN_NONE = op_t'(0);
  localparam op_t IMM_GEN_I    = op_t'(1);
  localparam op_t IMM_GEN_B    = op_t'(2);
  localparam op_t IMM_GEN_J    = op_t'(3);
  localparam op_t IMM_GEN_U    = op_t'(4);
  localparam op_t IMM_GEN_S    = op_t'(5);
  localparam op_t IMM_GEN_Z    = op_t'(6);
  localparam op_t IMM_GEN_SH   = op_t'(7);
endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: input/output valid-ready streams of the immediate generator pipeline
interface imm_gen_pipe_if #(
  parameter int XLEN = 32,
  parameter int TAG_W = 32
);
  import imm_gen_pipe_pkg::*;
  logic in_valid;
  logic in_ready;
  op_t in_op;
  logic [31:0] in_ir;
  logic [TAG_W-1:0] in_tag;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] out_imm;
  logic out_err;
  logic [TAG_W-1:0] out_tag;
  modport slave (
    input in_valid, in_op, in_ir, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_err, out_tag
  );
  modport master (
    output in_valid, in_op, in_ir, in_tag, out_ready,
    input in_ready, out_valid, out_imm, out_err, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe_core.sv
// imm_gen_core: combinational (op, ir) to extended immediate decoder
module imm_gen_core import imm_gen_pipe_pkg::*; #(
  parameter int XLEN = 32
) (
  input  op_t op_i,
  input  logic [31:0] ir_i,
  output logic [XLEN-1:0] imm_o,
  output logic err_o
);
  always_comb begin
    imm_o = '0;
    err_o = 1'b0;
    case (op_i)
      IMM_GEN_NONE: imm_o = '0;
      IMM_GEN_I:    imm_o = XLEN'($signed(ir_i[31:20]));
      IMM_GEN_B:    imm_o = XLEN'($signed({ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0}));
      IMM_GEN_J:    imm_o = XLEN'($signed({ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0}));
      IMM_GEN_U:    imm_o = XLEN'($signed({ir_i[31:12], 12'b0}));
      IMM_GEN_S:    imm_o = XLEN'($signed({ir_i[31:25], ir_i[11:7]}));
      IMM_GEN_Z:    imm_o = XLEN'(ir_i[19:15]);
      IMM_GEN_SH:   imm_o = XLEN == 64 ? XLEN'(ir_i[25:20]) : XLEN'(ir_i[24:20]);
      default:      err_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with a one-entry skid buffer and flush
module imm_gen_pipe import imm_gen_pipe_pkg::*; #(
  parameter int XLEN = 32,
  parameter int TAG_W = 32
) (
  input logic clk,
  input logic rst_n,
  input logic flush_i,
  imm_gen_pipe_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic err;
    logic [TAG_W-1:0] tag;
  } entry_t;
  entry_t in_e, out_d, out_q, skid_q;
  logic [XLEN-1:0] imm_c;
  logic err_c;
  logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic in_xfer, out_ld, out_load, skid_load;
  imm_gen_core #(.XLEN(XLEN)) u_core (
    .op_i(bus.in_op),
    .ir_i(bus.in_ir),
    .imm_o(imm_c),
    .err_o(err_c)
  );
  assign bus.in_ready = !skid_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm = out_q.imm;
  assign bus.out_err = out_q.err;
  assign bus.out_tag = out_q.tag;
  // skid drains first so ordering stays FIFO; flush only kills the valid bits
  always_comb begin
    in_e = {imm_c, err_c, bus.in_tag};
    in_xfer = bus.in_valid && !skid_valid_q;
    out_ld = !out_valid_q || bus.out_ready;
    out_d = skid_valid_q ? skid_q : in_e;
    out_load = out_ld && (skid_valid_q || in_xfer);
    skid_load = in_xfer && !out_ld;
    out_valid_d = flush_i ? 1'b0 : out_ld ? (skid_valid_q || in_xfer) : out_valid_q;
    skid_valid_d = flush_i ? 1'b0 : out_ld ? (skid_valid_q && in_xfer) : (skid_valid_q || in_xfer);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q <= '0;
      skid_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      if (out_load) out_q <= out_d;
      if (skid_load) skid_q <= in_e;
    end
  end
endmodule
